// File: rtl/demux_1_2_dt_pkg.sv
// Shared definitions for the 1:2 dead-time demux: FSM state encoding and counter width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package demux_1_2_dt_pkg;

    // S_DEAD is both the reset state and the break-before-make gap between routes.
    typedef enum logic [1:0] {
        S_DEAD = 2'd0,
        S_OUT0 = 2'd1,
        S_OUT1 = 2'd2
    } state_t;

    localparam int SW_CNT_W = 16;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/demux_1_2_dt_sync_bit.sv
// Multi-stage flop synchroniser for one asynchronous control bit; chain resets to 0.
// Latency: STAGES clock cycles from d to q.
// Backpressure: none, free-running.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronised out).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/demux_1_2_dt.sv
// Steers one 1-bit stream to one of two lines; switches only when the input is idle (or on timeout), with a dead-time gap.
// Latency: d_in -> d_out_x 2 cycles; d_sel -> switch start SYNC_STAGES cycles plus wait for idle.
// Backpressure: none; a pending switch is held until the input is idle or MAX_WAIT expires.
// Ports: clk, rst_n, d_sel (async route select), d_in, d_out_0/1, d_route (one-hot), d_forced (pulse), d_sw_cnt.
module demux_1_2_dt
    import demux_1_2_dt_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEAD_CYCLES = 4,
    parameter int   MAX_WAIT    = 1024,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                d_sel,
    input  logic                d_in,
    output logic                d_out_0,
    output logic                d_out_1,
    output logic [1:0]          d_route,
    output logic                d_forced,
    output logic [SW_CNT_W-1:0] d_sw_cnt
);

    localparam int DEAD_W = cnt_width(DEAD_CYCLES);
    localparam int WAIT_W = cnt_width(MAX_WAIT);

    localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(1);
    // Only meaningful when MAX_WAIT != 0; the timeout branch is gated on that.
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);
    localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

    logic                sel_s;
    logic                in_reg;
    state_t              state,    state_nxt;
    logic [DEAD_W-1:0]   dead_cnt, dead_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [SW_CNT_W-1:0] sw_nxt;
    logic                forced_nxt;
    logic                cur_sel;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_sel),
        .q     (sel_s)
    );

    // Route index the current output state corresponds to.
    assign cur_sel = (state == S_OUT1);

    always_comb begin
        state_nxt  = state;
        dead_nxt   = dead_cnt;
        wait_nxt   = wait_cnt;
        sw_nxt     = d_sw_cnt;
        forced_nxt = 1'b0;
        case (state)
            S_DEAD: begin
                dead_nxt = dead_cnt - DEAD_W'(1);
                // Route is decided by sel_s at the moment the gap ends, not when it began.
                if (dead_cnt == DEAD_LAST) begin
                    state_nxt = sel_s ? S_OUT1 : S_OUT0;
                    sw_nxt    = d_sw_cnt + SW_CNT_W'(1);
                    wait_nxt  = '0;
                end
            end
            S_OUT0, S_OUT1: begin
                if (sel_s == cur_sel) begin
                    // No switch requested, or a pending one was cancelled.
                    wait_nxt = '0;
                end else if (in_reg == IDLE_LEVEL) begin
                    // Idle takes priority over a coincident timeout: unforced switch.
                    state_nxt = S_DEAD;
                    dead_nxt  = DEAD_INIT;
                    wait_nxt  = '0;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                    state_nxt  = S_DEAD;
                    dead_nxt   = DEAD_INIT;
                    wait_nxt   = '0;
                    forced_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt = S_DEAD;
                dead_nxt  = DEAD_INIT;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_DEAD;
            dead_cnt <= DEAD_INIT;
            wait_cnt <= '0;
            d_sw_cnt <= '0;
            d_forced <= 1'b0;
            in_reg   <= IDLE_LEVEL;
            d_out_0  <= IDLE_LEVEL;
            d_out_1  <= IDLE_LEVEL;
            d_route  <= 2'b00;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            wait_cnt <= wait_nxt;
            d_sw_cnt <= sw_nxt;
            d_forced <= forced_nxt;
            in_reg   <= d_in;
            // Outputs and route follow the current state so d_route drops on the
            // same edge the old line goes idle.
            d_out_0  <= (state == S_OUT0) ? in_reg : IDLE_LEVEL;
            d_out_1  <= (state == S_OUT1) ? in_reg : IDLE_LEVEL;
            d_route  <= {state == S_OUT1, state == S_OUT0};
        end
    end

endmodule

// File: tb/tb_demux_1_2_dt.sv
// Self-checking bench for demux_1_2_dt: randomized stimulus, timestamp-based reference model, scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_1_2_dt;

    localparam int SYNC = 2;
    localparam int DEAD = 4;
    localparam int MAXW = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_sel = 1'b0;
    logic        d_in  = 1'b0;
    logic        d_out_0;
    logic        d_out_1;
    logic [1:0]  d_route;
    logic        d_forced;
    logic [15:0] d_sw_cnt;

    demux_1_2_dt #(
        .SYNC_STAGES (SYNC),
        .DEAD_CYCLES (DEAD),
        .MAX_WAIT    (MAXW),
        .IDLE_LEVEL  (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_sel    (d_sel),
        .d_in     (d_in),
        .d_out_0  (d_out_0),
        .d_out_1  (d_out_1),
        .d_route  (d_route),
        .d_forced (d_forced),
        .d_sw_cnt (d_sw_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        o0;
        logic        o1;
        logic [1:0]  route;
        logic        forced;
        logic [15:0] sw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: route as an integer (-1 = dead-time), absolute edge at
    // which the gap ends, edge at which the current pending request began.
    int   edge_n;
    int   route;
    int   dead_exit;
    int   pend_start;
    int   sw_total;
    int   forced_total;
    logic sel_hist[$];
    logic in_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_n     = 0;
        route      = -1;
        dead_exit  = DEAD;
        pend_start = -1;
        sw_total   = 0;
        sel_hist.delete();
        in_hist.delete();
    endtask

    // Called at each rising edge with the input values the DUT sampled there.
    task automatic model_step(input logic sel, input logic din);
        logic s;
        logic i;
        exp_t e;
        edge_n++;
        sel_hist.push_back(sel);
        in_hist.push_back(din);
        s = (edge_n > SYNC) ? sel_hist[edge_n - 1 - SYNC] : 1'b0;
        i = (edge_n > 1)    ? in_hist[edge_n - 2]         : 1'b0;
        e.o0     = (route == 0) ? i : 1'b0;
        e.o1     = (route == 1) ? i : 1'b0;
        e.route  = (route == 0) ? 2'b01 : ((route == 1) ? 2'b10 : 2'b00);
        e.forced = 1'b0;
        if (route < 0) begin
            if (edge_n == dead_exit) begin
                route      = int'(s);
                sw_total   = sw_total + 1;
                pend_start = -1;
            end
        end else if (int'(s) == route) begin
            pend_start = -1;
        end else if (i == 1'b0) begin
            route      = -1;
            dead_exit  = edge_n + DEAD;
            pend_start = -1;
        end else begin
            if (pend_start < 0) pend_start = edge_n;
            if (edge_n - pend_start == MAXW - 1) begin
                e.forced     = 1'b1;
                forced_total = forced_total + 1;
                route        = -1;
                dead_exit    = edge_n + DEAD;
                pend_start   = -1;
            end
        end
        e.sw = 16'(sw_total);
        exp_q.push_back(e);
    endtask

    // One clock: the model sees what the DUT samples, then new inputs are driven.
    task automatic cycle(input logic nsel, input logic nin);
        @(posedge clk);
        model_step(d_sel, d_in);
        #1;
        d_sel = nsel;
        d_in  = nin;
    endtask

    // Monitor: pops one expectation per clock and checks invariants.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("d_out_0",  32'(d_out_0),  32'(e.o0));
            chk("d_out_1",  32'(d_out_1),  32'(e.o1));
            chk("d_route",  32'(d_route),  32'(e.route));
            chk("d_forced", 32'(d_forced), 32'(e.forced));
            chk("d_sw_cnt", 32'(d_sw_cnt), 32'(e.sw));
            chk("route_not_both", 32'(d_route == 2'b11), 32'd0);
            chk("out0_gated", 32'(d_out_0 && !d_route[0]), 32'd0);
            chk("out1_gated", 32'(d_out_1 && !d_route[1]), 32'd0);
        end
    end

    initial begin
        int   cyc;
        int   len;
        int   mode;
        int   waited;
        logic nsel;
        logic nin;

        forced_total = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst d_out_0",  32'(d_out_0),  32'd0);
        chk("rst d_out_1",  32'(d_out_1),  32'd0);
        chk("rst d_route",  32'(d_route),  32'd0);
        chk("rst d_forced", 32'(d_forced), 32'd0);
        chk("rst d_sw_cnt", 32'(d_sw_cnt), 32'd0);
        #20 rst_n = 1'b1;

        // Exit from reset onto route 0, then a short pulse train on it.
        for (int k = 0; k < 12; k++) cycle(1'b0, (k >= 6 && k < 9) ? 1'b1 : 1'b0);

        // Random segments: held select with random, stuck-high or sparse input.
        cyc = 0;
        while (cyc < 10000) begin
            nsel = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0:       nin = 1'($urandom_range(0, 1));
                    1:       nin = (k < len - 2) ? 1'b1 : 1'b0;
                    default: nin = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
                endcase
                cycle(nsel, nin);
                cyc++;
            end
        end

        // Reach route 1 with idle input, bounded.
        waited = 0;
        while (d_route != 2'b10 && waited < 200) begin
            cycle(1'b1, 1'b0);
            waited++;
        end
        chk("route1 reached", 32'(d_route), 32'h2);

        // Pulse on line 1, then async reset mid-pulse.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1);
        chk("pulse on d_out_1", 32'(d_out_1), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async d_out_1", 32'(d_out_1),  32'd0);
        chk("async d_route", 32'(d_route),  32'd0);
        chk("async d_sw_cnt", 32'(d_sw_cnt), 32'd0);
        d_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        model_reset();
        rst_n = 1'b1;

        // Full dead-time after release, then route 1 with a short pulse.
        for (int k = 0; k < 16; k++) cycle(1'b1, (k == 10) ? 1'b1 : 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("forced switches in model: %0d", forced_total);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
